// File: rtl/dvi_data_dec.sv
// dvi_data_dec: TMDS data-channel decoder for one DVI channel.
// Two-stage pipeline (symbol register, decode register) plus a word-alignment
// FSM that locks on runs of control tokens and pulses bitslip to the SERDES.
// Optional build macro DVI_DEC_DISPCHK_EN adds running-disparity checking
// that drives err_cnt; without it err_cnt is tied to zero.
module dvi_data_dec #(
   parameter int LOCK_TOKENS = 32,
   parameter int WIN_LEN     = 2048,
   parameter int SLIP_WAIT   = 16
`ifdef DVI_DEC_DISPCHK_EN
   , parameter int DISP_MAX  = 20
`endif
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [9:0]  ch_in,
   output logic [9:0]  ch_out,
   output logic        ch_de,
   output logic        locked,
   output logic        bitslip,
   output logic [15:0] err_cnt
);

   localparam int RUN_W  = $clog2(LOCK_TOKENS + 1);
   localparam int WIN_W  = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
   localparam int SLIP_W = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT) : 1;
   localparam logic [RUN_W-1:0]  RUN_MAX   = RUN_W'(LOCK_TOKENS);
   localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WIN_LEN - 1);
   localparam logic [SLIP_W-1:0] SLIP_LAST = SLIP_W'(SLIP_WAIT - 1);

   typedef enum logic [1:0] {
      ST_SEARCH    = 2'd0,
      ST_SLIP_WAIT = 2'd1,
      ST_LOCKED    = 2'd2
   } state_t;

   // TMDS transition-minimised data recovery (XOR/XNOR chain after optional inversion).
   function automatic logic [7:0] tmds_data(input logic [9:0] sym);
      logic [7:0] q;
      logic [7:0] d;
      q    = sym[9] ? ~sym[7:0] : sym[7:0];
      d[0] = q[0];
      for (int i = 1; i < 8; i++) begin
         d[i] = sym[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
      end
      return d;
   endfunction

   logic [9:0]        sym_r;
   logic              sym_vld_r;
   logic              is_tok_s;
   logic [1:0]        tok_ctl_s;
   state_t            state_r;
   state_t            state_nxt_s;
   logic [RUN_W-1:0]  run_cnt_r;
   logic [WIN_W-1:0]  win_cnt_r;
   logic [SLIP_W-1:0] slip_cnt_r;
   logic              run_seen_r;
   logic              run_full_s;
   logic              run_ok_s;
   logic              win_wrap_s;
   logic              win_clr_s;
   logic              locked_nxt_s;
   logic              bitslip_nxt_s;

   assign run_full_s = (run_cnt_r == RUN_MAX);
   assign win_wrap_s = (win_cnt_r == WIN_LAST);
   // A run completing exactly at the wrap still counts for this window.
   assign run_ok_s   = run_seen_r | run_full_s;

   // Stage 0: capture the raw symbol; the valid flag keeps reset-time contents out of stage 1.
   always_ff @(posedge clk) begin
      if (rst) begin
         sym_r     <= 10'h000;
         sym_vld_r <= 1'b0;
      end else begin
         sym_r     <= ch_in;
         sym_vld_r <= 1'b1;
      end
   end

   // Control-token recognition on the stage-0 symbol (exact match only).
   always_comb begin
      is_tok_s  = 1'b1;
      tok_ctl_s = 2'b00;
      case (sym_r)
         10'b1101010100: tok_ctl_s = 2'b00;
         10'b0010101011: tok_ctl_s = 2'b01;
         10'b0101010100: tok_ctl_s = 2'b10;
         10'b1010101011: tok_ctl_s = 2'b11;
         default: begin
            is_tok_s  = 1'b0;
            tok_ctl_s = 2'b00;
         end
      endcase
   end

   // Stage 1: decoded outputs; data symbols keep the last C1C0 in ch_out[9:8].
   always_ff @(posedge clk) begin
      if (rst) begin
         ch_out <= 10'h000;
         ch_de  <= 1'b0;
      end else if (sym_vld_r) begin
         if (is_tok_s) begin
            ch_out <= {tok_ctl_s, 8'h00};
            ch_de  <= 1'b0;
         end else begin
            ch_out <= {ch_out[9:8], tmds_data(sym_r)};
            ch_de  <= 1'b1;
         end
      end else begin
         ch_out <= ch_out;
         ch_de  <= ch_de;
      end
   end

   // Alignment FSM next-state: lock takes priority over a simultaneous window wrap.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_SEARCH: begin
            if (run_full_s) begin
               state_nxt_s = ST_LOCKED;
            end else if (win_wrap_s && !run_ok_s) begin
               state_nxt_s = ST_SLIP_WAIT;
            end else begin
               state_nxt_s = ST_SEARCH;
            end
         end
         ST_SLIP_WAIT: begin
            if (slip_cnt_r == SLIP_LAST) begin
               state_nxt_s = ST_SEARCH;
            end else begin
               state_nxt_s = ST_SLIP_WAIT;
            end
         end
         ST_LOCKED: begin
            if (win_wrap_s && !run_ok_s) begin
               state_nxt_s = ST_SEARCH;
            end else begin
               state_nxt_s = ST_LOCKED;
            end
         end
         default: state_nxt_s = ST_SEARCH;
      endcase
   end

   // Alignment FSM outputs: bitslip only on the SEARCH->SLIP_WAIT transition.
   always_comb begin
      locked_nxt_s  = (state_nxt_s == ST_LOCKED);
      bitslip_nxt_s = (state_r == ST_SEARCH) && (state_nxt_s == ST_SLIP_WAIT);
      win_clr_s     = (state_r == ST_SLIP_WAIT) ||
                      ((state_r == ST_SEARCH) && (state_nxt_s == ST_LOCKED));
   end

   // Alignment FSM state register with registered status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_SEARCH;
         locked  <= 1'b0;
         bitslip <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         locked  <= locked_nxt_s;
         bitslip <= bitslip_nxt_s;
      end
   end

   // Token-run, window, slip-wait counters and the per-window run_seen flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         run_cnt_r  <= '0;
         win_cnt_r  <= '0;
         slip_cnt_r <= '0;
         run_seen_r <= 1'b0;
      end else begin
         if (state_r == ST_SLIP_WAIT) begin
            run_cnt_r <= '0;
         end else if (sym_vld_r && is_tok_s) begin
            run_cnt_r <= run_full_s ? run_cnt_r : run_cnt_r + RUN_W'(1);
         end else if (sym_vld_r) begin
            run_cnt_r <= '0;
         end else begin
            run_cnt_r <= run_cnt_r;
         end

         if (win_clr_s || win_wrap_s) begin
            win_cnt_r <= '0;
         end else begin
            win_cnt_r <= win_cnt_r + WIN_W'(1);
         end

         if (state_r == ST_SLIP_WAIT) begin
            slip_cnt_r <= slip_cnt_r + SLIP_W'(1);
         end else begin
            slip_cnt_r <= '0;
         end

         // A restarted window starts with no run credited to it.
         if (win_clr_s || win_wrap_s) begin
            run_seen_r <= 1'b0;
         end else if (run_full_s) begin
            run_seen_r <= 1'b1;
         end else begin
            run_seen_r <= run_seen_r;
         end
      end
   end

`ifdef DVI_DEC_DISPCHK_EN
   localparam logic signed [7:0] DMAX = 8'(DISP_MAX);

   // Number of ones in a 10-bit symbol.
   function automatic logic [3:0] ones10(input logic [9:0] v);
      logic [3:0] n;
      n = 4'd0;
      for (int i = 0; i < 10; i++) begin
         n = n + {3'b000, v[i]};
      end
      return n;
   endfunction

   logic signed [7:0] disp_r;
   logic signed [8:0] diff_s;
   logic signed [8:0] sum_s;
   logic signed [7:0] disp_nxt_s;
   logic              err_hit_s;
   logic              err_pend_r;

   // Running disparity update (ones minus zeros), clamped to the 8-bit range.
   always_comb begin
      diff_s = $signed({4'b0000, ones10(sym_r), 1'b0}) - 9'sd10;
      sum_s  = {disp_r[7], disp_r} + diff_s;
      if (sum_s > 9'sd127) begin
         disp_nxt_s = 8'sd127;
      end else if (sum_s < -9'sd128) begin
         disp_nxt_s = -8'sd128;
      end else begin
         disp_nxt_s = sum_s[7:0];
      end
      err_hit_s = (disp_nxt_s > DMAX) || (disp_nxt_s < -DMAX);
   end

   // Disparity state alongside stage 1; the error count lands one cycle later.
   always_ff @(posedge clk) begin
      if (rst) begin
         disp_r     <= 8'sd0;
         err_pend_r <= 1'b0;
         err_cnt    <= 16'h0000;
      end else begin
         if (sym_vld_r && is_tok_s) begin
            disp_r     <= 8'sd0;
            err_pend_r <= 1'b0;
         end else if (sym_vld_r) begin
            disp_r     <= disp_nxt_s;
            err_pend_r <= err_hit_s;
         end else begin
            disp_r     <= disp_r;
            err_pend_r <= 1'b0;
         end
         if (err_pend_r && (err_cnt != 16'hFFFF)) begin
            err_cnt <= err_cnt + 16'h0001;
         end else begin
            err_cnt <= err_cnt;
         end
      end
   end
`else
   assign err_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_dvi_data_dec.sv
// tb_dvi_data_dec: directed self-checking bench for dvi_data_dec.
// Edges after a reset release are numbered 1,2,...; a symbol driven before
// edge m is captured at edge m and decoded at edge m+1.
module tb_dvi_data_dec;

   logic        clk;
   logic        rst;
   logic [9:0]  ch_in;
   logic [9:0]  ch_out;
   logic        ch_de;
   logic        locked;
   logic        bitslip;
   logic [15:0] err_cnt;

   int total;
   int bad;

   localparam logic [9:0] TOK0 = 10'h354;
   localparam logic [9:0] DAT  = 10'h163;

   dvi_data_dec dut (
      .clk     (clk),
      .rst     (rst),
      .ch_in   (ch_in),
      .ch_out  (ch_out),
      .ch_de   (ch_de),
      .locked  (locked),
      .bitslip (bitslip),
      .err_cnt (err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic [9:0] sym);
      rst   = 1'b1;
      ch_in = sym;
      repeat (3) step();
      rst = 1'b0;
   endtask

   logic [9:0]  stim [11];
   logic [10:0] expv [11];

   initial begin
      int bs;
      int first_bs;
      int second_bs;
      int lock_at;
      int n;
      total = 0;
      bad   = 0;

      stim[0]  = 10'h354; expv[0]  = {1'b0, 10'h000};
      stim[1]  = 10'h0AB; expv[1]  = {1'b0, 10'h100};
      stim[2]  = 10'h154; expv[2]  = {1'b0, 10'h200};
      stim[3]  = 10'h2AB; expv[3]  = {1'b0, 10'h300};
      stim[4]  = 10'h0AB; expv[4]  = {1'b0, 10'h100};
      stim[5]  = 10'h163; expv[5]  = {1'b1, 10'h1A5};
      stim[6]  = 10'h39C; expv[6]  = {1'b1, 10'h1A5};
      stim[7]  = 10'h0F0; expv[7]  = {1'b1, 10'h1EE};
      stim[8]  = 10'h2AB; expv[8]  = {1'b0, 10'h300};
      stim[9]  = 10'h0F0; expv[9]  = {1'b1, 10'h3EE};
      stim[10] = 10'h3FF; expv[10] = {1'b1, 10'h300};

      // Reset values during reset and on the first edge after release.
      do_reset(10'h3FF);
      check_val("rst_out", {ch_de, ch_out}, 11'h000);
      check_val("rst_stat", {locked, bitslip}, 2'b00);
      for (int i = 0; i < 12; i++) begin
         ch_in = (i < 11) ? stim[i] : DAT;
         step();
         if (i == 0) begin
            check_val("rel_out", {ch_de, ch_out}, 11'h000);
            check_val("rel_stat", {locked, bitslip}, 2'b00);
         end else begin
            check_val($sformatf("dec%0d", i - 1), {ch_de, ch_out}, expv[i-1]);
         end
      end

      // Disparity: three all-ones data symbols push disparity to 30.
      do_reset(10'h354);
      for (int i = 1; i <= 6; i++) begin
         ch_in = (i <= 3) ? 10'h3FF : TOK0;
         step();
         if (i == 4) check_val("err_early", err_cnt, 16'h0000);
      end
`ifdef DVI_DEC_DISPCHK_EN
      check_val("err_cnt", err_cnt, 16'h0001);
`else
      check_val("err_cnt", err_cnt, 16'h0000);
`endif

      // Lock after exactly 32 tokens, then loss after one window of data.
      do_reset(DAT);
      bs = 0;
      for (n = 1; n <= 2082; n++) begin
         ch_in = (n <= 32) ? TOK0 : DAT;
         step();
         if (bitslip) bs++;
         if (n == 33) begin
            check_val("lk_tok32", {ch_de, ch_out}, 11'h000);
            check_val("lk_pre", locked, 1'b0);
         end
         if (n == 34)   check_val("lk_rise", locked, 1'b1);
         if (n == 2081) check_val("lk_hold", locked, 1'b1);
         if (n == 2082) check_val("lk_loss", locked, 1'b0);
      end
      check_val("lk_nobs", bs, 0);

      // Reset while locked.
      do_reset(DAT);
      for (n = 1; n <= 34; n++) begin
         ch_in = (n <= 32) ? TOK0 : DAT;
         step();
      end
      check_val("rl_lock", locked, 1'b1);
      rst = 1'b1;
      step();
      check_val("rl_rst", {locked, ch_de, ch_out}, 12'h000);
      rst = 1'b0;

      // Run completes on the very wrap cycle: lock wins, no bitslip.
      do_reset(DAT);
      bs = 0;
      for (n = 1; n <= 2050; n++) begin
         ch_in = (n >= 2015 && n <= 2046) ? TOK0 : DAT;
         step();
         if (bitslip) bs++;
         if (n == 2047) check_val("sim_pre", locked, 1'b0);
         if (n == 2048) check_val("sim_lock", locked, 1'b1);
      end
      check_val("sim_nobs", bs, 0);

      // Alignment search: bitslip every WIN_LEN+SLIP_WAIT cycles, then lock on tokens.
      do_reset(DAT);
      bs = 0;
      first_bs = 0;
      second_bs = 0;
      for (n = 1; n <= 4120; n++) begin
         ch_in = DAT;
         step();
         if (bitslip) begin
            bs++;
            if (first_bs == 0) first_bs = n;
            else if (second_bs == 0) second_bs = n;
         end
      end
      check_val("al_count", bs, 2);
      check_val("al_first", first_bs, 2048);
      check_val("al_second", second_bs, 4112);
      check_val("al_unlock", locked, 1'b0);
      lock_at = 0;
      for (int k = 0; k < 100 && lock_at == 0; k++) begin
         ch_in = TOK0;
         step();
         n++;
         if (locked) lock_at = n - 1;
      end
      check_val("al_lock_at", lock_at, 4161);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
